// File: rtl/syr2k_controller.sv
`default_nettype none
// ============================================================================
// Module   : syr2k_controller
// Purpose  : Sequencer for C = beta*C + alpha*(A*B^T + B*A^T).
//            Walks the lower triangle of the NxN matrix C in row order:
//            (0,0), (1,0), (1,1), (2,0), ...
//            For each element it accumulates K operand pairs from the A/B
//            memories, reads the old C value and writes the scaled result.
//            Off-diagonal results are also written to the mirrored
//            upper-triangle address.
// Ports    : clk, rst_n          - clock, async active-low reset
//            start, alpha, beta  - host request; scales latched at start
//            busy, done          - run in progress / one-cycle completion pulse
//            ab_addr_i/j         - A/B row-i and row-j addresses (row*K+k)
//            a/b_rdata_i/j       - A/B read data, one cycle after address
//            c_addr, c_rdata     - C address (row*N+col) and read data
//            c_we, c_wdata       - C write strobe and write data
// Revision : 1.0 - initial release
// ============================================================================
module syr2k_controller #(
  parameter int N  = 4,
  parameter int K  = 4,
  parameter int DW = 32,
  localparam int ABW = (N * K > 1) ? $clog2(N * K) : 1,
  localparam int CW  = (N * N > 1) ? $clog2(N * N) : 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [DW-1:0]  alpha,
  input  logic [DW-1:0]  beta,
  output logic           busy,
  output logic           done,
  output logic [ABW-1:0] ab_addr_i,
  output logic [ABW-1:0] ab_addr_j,
  input  logic [DW-1:0]  a_rdata_i,
  input  logic [DW-1:0]  a_rdata_j,
  input  logic [DW-1:0]  b_rdata_i,
  input  logic [DW-1:0]  b_rdata_j,
  output logic [CW-1:0]  c_addr,
  input  logic [DW-1:0]  c_rdata,
  output logic           c_we,
  output logic [DW-1:0]  c_wdata
);

  // Row counter must be able to hold N so the "past last row" test works.
  localparam int IW = $clog2(N + 1);
  localparam int KW = (K > 1) ? $clog2(K) : 1;

  localparam logic [2:0] c_IDLE   = 3'd0;
  localparam logic [2:0] c_ACC    = 3'd1;
  localparam logic [2:0] c_CRD    = 3'd2;
  localparam logic [2:0] c_WB     = 3'd3;
  localparam logic [2:0] c_MIRROR = 3'd4;
  localparam logic [2:0] c_DONE   = 3'd5;

  logic [2:0]    r_state;
  logic [IW-1:0] r_i;
  logic [IW-1:0] r_j;
  logic [KW-1:0] r_k;
  logic [DW-1:0] r_acc;
  logic [DW-1:0] r_alpha;
  logic [DW-1:0] r_beta;
  logic [DW-1:0] r_hold;

  logic [DW-1:0] w_pair;
  logic [DW-1:0] w_result;
  logic [IW-1:0] w_i_inc;
  logic          w_last_k;
  logic          w_last_row;

  // All arithmetic is evaluated at DW bits, so it wraps mod 2^DW.
  assign w_pair     = a_rdata_i * b_rdata_j + b_rdata_i * a_rdata_j;
  assign w_result   = r_beta * c_rdata + r_alpha * r_acc;
  assign w_i_inc    = r_i + IW'(1);
  assign w_last_k   = (r_k == KW'(K - 1));
  assign w_last_row = (w_i_inc == IW'(N));

  assign busy = (r_state != c_IDLE);
  assign done = (r_state == c_DONE);

  // Outputs are decoded from the state registers so that an asynchronous
  // reset removes c_we and busy in the same instant. Address products may
  // truncate their operands: the true address always fits in the port width,
  // so the modular result is exact.
  always_comb begin
    ab_addr_i = '0;
    ab_addr_j = '0;
    c_addr    = '0;
    c_we      = 1'b0;
    c_wdata   = '0;
    case (r_state)
      c_ACC: begin
        ab_addr_i = ABW'(r_i) * ABW'(K) + ABW'(r_k);
        ab_addr_j = ABW'(r_j) * ABW'(K) + ABW'(r_k);
      end
      c_CRD: begin
        c_addr = CW'(r_i) * CW'(N) + CW'(r_j);
      end
      c_WB: begin
        c_addr  = CW'(r_i) * CW'(N) + CW'(r_j);
        c_we    = 1'b1;
        c_wdata = w_result;
      end
      c_MIRROR: begin
        // c_rdata is no longer valid here, so replay the held result.
        c_addr  = CW'(r_j) * CW'(N) + CW'(r_i);
        c_we    = 1'b1;
        c_wdata = r_hold;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_IDLE;
      r_i     <= '0;
      r_j     <= '0;
      r_k     <= '0;
      r_acc   <= '0;
      r_alpha <= '0;
      r_beta  <= '0;
      r_hold  <= '0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (start) begin
            r_alpha <= alpha;
            r_beta  <= beta;
            r_i     <= '0;
            r_j     <= '0;
            r_k     <= '0;
            r_acc   <= '0;
            r_state <= c_ACC;
          end
        end
        c_ACC: begin
          // Data for address k-1 arrives during the cycle that issues k.
          if (r_k != '0) r_acc <= r_acc + w_pair;
          if (w_last_k) begin
            r_k     <= '0;
            r_state <= c_CRD;
          end else begin
            r_k <= r_k + KW'(1);
          end
        end
        c_CRD: begin
          r_acc   <= r_acc + w_pair;
          r_state <= c_WB;
        end
        c_WB, c_MIRROR: begin
          if ((r_state == c_WB) && (r_i != r_j)) begin
            r_hold  <= w_result;
            r_state <= c_MIRROR;
          end else begin
            // Advance to the next lower-triangle element.
            r_acc <= '0;
            r_k   <= '0;
            if (r_j < r_i) begin
              r_j     <= r_j + IW'(1);
              r_state <= c_ACC;
            end else begin
              r_j     <= '0;
              r_i     <= w_i_inc;
              r_state <= w_last_row ? c_DONE : c_ACC;
            end
          end
        end
        c_DONE: begin
          r_i     <= '0;
          r_j     <= '0;
          r_state <= c_IDLE;
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_syr2k_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_syr2k_controller
// Purpose  : Self-checking bench for syr2k_controller. Two instances share
//            one set of memory contents (only one runs at a time):
//            instance 0 with N=2,K=2 and instance 1 with N=1,K=1.
//            Results are compared against a matrix-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_syr2k_controller;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start0 = 1'b0;
  logic        start1 = 1'b0;
  logic [31:0] alpha = '0;
  logic [31:0] beta = '0;

  always #5 clk = ~clk;

  // instance 0 (N=2, K=2)
  logic        busy0, done0, c_we0;
  logic [1:0]  abi0, abj0, caddr0;
  logic [31:0] ai0, aj0, bi0, bj0, crd0, cwd0;
  // instance 1 (N=1, K=1)
  logic        busy1, done1, c_we1;
  logic [0:0]  abi1, abj1, caddr1;
  logic [31:0] ai1, aj1, bi1, bj1, crd1, cwd1;

  logic [31:0] ma [16];
  logic [31:0] mb [16];
  logic [31:0] mc [16];
  int          wa [$];
  logic [31:0] wd [$];

  int n_checks = 0;
  int n_errs   = 0;
  int last_base;

  syr2k_controller #(.N(2), .K(2), .DW(32)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .alpha(alpha), .beta(beta),
    .busy(busy0), .done(done0), .ab_addr_i(abi0), .ab_addr_j(abj0),
    .a_rdata_i(ai0), .a_rdata_j(aj0), .b_rdata_i(bi0), .b_rdata_j(bj0),
    .c_addr(caddr0), .c_rdata(crd0), .c_we(c_we0), .c_wdata(cwd0)
  );

  syr2k_controller #(.N(1), .K(1), .DW(32)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .alpha(alpha), .beta(beta),
    .busy(busy1), .done(done1), .ab_addr_i(abi1), .ab_addr_j(abj1),
    .a_rdata_i(ai1), .a_rdata_j(aj1), .b_rdata_i(bi1), .b_rdata_j(bj1),
    .c_addr(caddr1), .c_rdata(crd1), .c_we(c_we1), .c_wdata(cwd1)
  );

  // Synchronous memories with one cycle read latency; writes are logged.
  always @(posedge clk) begin
    ai0  <= ma[abi0];
    aj0  <= ma[abj0];
    bi0  <= mb[abi0];
    bj0  <= mb[abj0];
    crd0 <= mc[caddr0];
    ai1  <= ma[abi1];
    aj1  <= ma[abj1];
    bi1  <= mb[abi1];
    bj1  <= mb[abj1];
    crd1 <= mc[caddr1];
    if (c_we0) begin
      wa.push_back(int'(caddr0));
      wd.push_back(cwd0);
    end
    if (c_we1) begin
      wa.push_back(int'(caddr1));
      wd.push_back(cwd1);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)", tag, got, got, exp, exp);
    end
  endtask

  function automatic logic get_busy(input int inst);
    return (inst == 0) ? busy0 : busy1;
  endfunction

  function automatic logic get_done(input int inst);
    return (inst == 0) ? done0 : done1;
  endfunction

  // Reference: C[i][j] = beta*C[i][j] + alpha * sum_k(A[i][k]B[j][k] + B[i][k]A[j][k])
  function automatic logic [31:0] ref_elem(input int n, input int kk, input int i, input int j,
                                           input logic [31:0] al, input logic [31:0] be);
    logic [31:0] s;
    s = '0;
    for (int k = 0; k < kk; k++)
      s = s + ma[i*kk+k] * mb[j*kk+k] + mb[i*kk+k] * ma[j*kk+k];
    return be * mc[i*n+j] + al * s;
  endfunction

  // One complete run on the chosen instance, checked for cycle count,
  // done pulse shape and the full ordered write sequence.
  task automatic run(input int inst, input int n, input int kk,
                     input logic [31:0] al, input logic [31:0] be, input bit poke);
    int idx;
    int exp_cyc;
    int p;
    logic [31:0] r;
    last_base = wa.size();
    @(negedge clk);
    alpha = al;
    beta  = be;
    if (inst == 0) start0 = 1'b1; else start1 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    start1 = 1'b0;
    check("busy_rise", 32'(get_busy(inst)), 32'd1);
    idx = 0;
    while (!get_done(inst) && idx < 500) begin
      if (poke) begin
        if (inst == 0) start0 = (idx == 3); else start1 = (idx == 3);
        alpha = (idx == 3) ? ~al : al;
      end
      @(negedge clk);
      idx++;
    end
    start0 = 1'b0;
    start1 = 1'b0;
    alpha  = al;
    exp_cyc = (n * (n + 1) / 2) * (kk + 2) + (n * (n - 1) / 2);
    check("done_cycle", 32'(idx), 32'(exp_cyc));
    check("busy_at_done", 32'(get_busy(inst)), 32'd1);
    @(negedge clk);
    check("done_pulse_end", 32'(get_done(inst)), 32'd0);
    check("busy_after_done", 32'(get_busy(inst)), 32'd0);
    check("write_count", 32'(wa.size() - last_base), 32'(n * n));
    p = last_base;
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j <= i; j++) begin
        r = ref_elem(n, kk, i, j, al, be);
        if (p < wa.size()) begin
          check("wr_addr", 32'(wa[p]), 32'(i * n + j));
          check("wr_data", wd[p], r);
        end
        p++;
        if (i != j) begin
          if (p < wa.size()) begin
            check("mirror_addr", 32'(wa[p]), 32'(j * n + i));
            check("mirror_data", wd[p], r);
          end
          p++;
        end
      end
    end
  endtask

  task automatic load_basic(input logic [31:0] cval);
    for (int x = 0; x < 4; x++) begin
      ma[x] = 32'(x + 1);
      mb[x] = 32'(x + 5);
      mc[x] = cval;
    end
  endtask

  initial begin
    int base;
    bit bad;
    for (int x = 0; x < 16; x++) begin
      ma[x] = '0;
      mb[x] = '0;
      mc[x] = '0;
    end

    // Reset state
    #12;
    check("rst_busy", 32'(busy0), 32'd0);
    check("rst_done", 32'(done0), 32'd0);
    check("rst_we", 32'(c_we0), 32'd0);
    check("rst_abi", 32'(abi0), 32'd0);
    check("rst_caddr", 32'(caddr0), 32'd0);
    check("rst_wdata", cwd0, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Basic run with a start pulse injected while busy
    load_basic(32'd0);
    run(0, 2, 2, 32'd1, 32'd0, 1'b1);
    check("basic_00", wd[last_base+0], 32'd34);
    check("basic_10", wd[last_base+1], 32'd62);
    check("basic_01", wd[last_base+2], 32'd62);
    check("basic_11", wd[last_base+3], 32'd106);
    repeat (3) @(negedge clk);
    check("no_restart", 32'(busy0), 32'd0);

    // Scaled run
    load_basic(32'd1);
    run(0, 2, 2, 32'd32412, 32'd2123, 1'b0);
    check("scaled_00", wd[last_base+0], 32'd1104131);
    check("scaled_10", wd[last_base+1], 32'd2011667);
    check("scaled_01", wd[last_base+2], 32'd2011667);
    check("scaled_11", wd[last_base+3], 32'd3437795);

    // Single element, no mirror
    ma[0] = 32'd3;
    mb[0] = 32'd4;
    mc[0] = 32'd1;
    run(1, 1, 1, 32'd2, 32'd5, 1'b0);
    check("n1_value", wd[last_base], 32'd53);

    // Wrap-around truncation
    ma[0] = 32'h0001_0000;
    mb[0] = 32'h0001_0000;
    mc[0] = 32'h1234_5678;
    run(1, 1, 1, 32'h0001_0000, 32'd0, 1'b0);
    check("wrap_value", wd[last_base], 32'd0);

    // Reset during the ACC phase of element (1,0)
    load_basic(32'd0);
    base = wa.size();
    @(negedge clk);
    alpha  = 32'd1;
    beta   = 32'd0;
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy0), 32'd0);
    check("abort_we", 32'(c_we0), 32'd0);
    repeat (3) @(negedge clk);
    check("abort_we_hold", 32'(c_we0), 32'd0);
    check("abort_wr_count", 32'(wa.size() - base), 32'd1);
    bad = 1'b0;
    for (int x = base; x < wa.size(); x++)
      if (wa[x] == 1 || wa[x] == 2) bad = 1'b1;
    check("abort_no_mirror_wr", 32'(bad), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("abort_idle", 32'(busy0), 32'd0);
    run(0, 2, 2, 32'd1, 32'd0, 1'b0);
    check("rerun_00", wd[last_base+0], 32'd34);
    check("rerun_10", wd[last_base+1], 32'd62);
    check("rerun_11", wd[last_base+3], 32'd106);

    // Randomized runs against the reference model
    for (int t = 0; t < 6; t++) begin
      for (int x = 0; x < 4; x++) begin
        ma[x] = $urandom;
        mb[x] = $urandom;
        mc[x] = $urandom;
      end
      run(0, 2, 2, $urandom, $urandom, 1'($urandom_range(0, 1)));
    end
    for (int t = 0; t < 4; t++) begin
      ma[0] = $urandom;
      mb[0] = $urandom;
      mc[0] = $urandom;
      run(1, 1, 1, $urandom, $urandom, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
`default_nettype wire
